// File: rtl/chip8_pkg.sv
// ============================================================================
// Module      : chip8_pkg
// Description : Shared CHIP-8 ALU sequencing types, opcodes and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chip8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_WB_X = 3'd3,
        ST_WB_Y = 3'd4,
        ST_WB_F = 3'd5
    } ctrl_state_t;

    localparam logic [3:0] c_ALU_ASSIGN      = 4'h0;
    localparam logic [3:0] c_ALU_OR          = 4'h1;
    localparam logic [3:0] c_ALU_AND         = 4'h2;
    localparam logic [3:0] c_ALU_XOR         = 4'h3;
    localparam logic [3:0] c_ALU_ADD         = 4'h4;
    localparam logic [3:0] c_ALU_SUB         = 4'h5;
    localparam logic [3:0] c_ALU_SHR         = 4'h6;
    localparam logic [3:0] c_ALU_SUBN        = 4'h7;
    localparam logic [3:0] c_ALU_SHL         = 4'hE;

    localparam logic [3:0] c_VF_IDX          = 4'hF;
    localparam logic [3:0] c_INSTR_ALU_CLASS = 4'h8;

    function automatic logic is_legal_alu_instr(input logic [15:0] instr);
        logic [3:0] n;
        n = instr[3:0];
        return (instr[15:12] == c_INSTR_ALU_CLASS) &&
               ((n <= c_ALU_SUBN) || (n == c_ALU_SHL));
    endfunction

    // Shifts write the shifted value back into Y as well as X.
    function automatic logic needs_wb_y(input logic [3:0] n);
        return (n == c_ALU_SHR) || (n == c_ALU_SHL);
    endfunction

    function automatic logic needs_wb_f(input logic [3:0] n);
        return (n == c_ALU_ADD) || (n == c_ALU_SUB) || (n == c_ALU_SHR) ||
               (n == c_ALU_SUBN) || (n == c_ALU_SHL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ctrl.sv
// ============================================================================
// Module      : alu_ctrl
// Description : Sequencer for CHIP-8 0x8XYN instructions: reads Vx/Vy, drives
//               the external ALU and writes back X, Y and VF in order.
//               Build option: ALU_CTRL_VF_RESET_EN (logic ops also clear VF).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl
    import chip8_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    output logic [3:0]  rf_raddr_x,
    output logic [3:0]  rf_raddr_y,
    input  logic [7:0]  rf_rdata_x,
    input  logic [7:0]  rf_rdata_y,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    output logic [3:0]  alu_opcode,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry,
    input  logic        alu_err,
    output logic        busy,
    output logic        done,
    output logic        err
);

    ctrl_state_t r_state;
    ctrl_state_t w_next;

    logic [11:0] r_instr;
    logic [7:0]  r_op1;
    logic [7:0]  r_op2;
    logic        r_flag;
    logic        r_ill_pend;

    logic [3:0]  w_x;
    logic [3:0]  w_y;
    logic [3:0]  w_n;
    logic        w_vf_clear;
    logic        w_need_f;

    assign w_x = r_instr[11:8];
    assign w_y = r_instr[7:4];
    assign w_n = r_instr[3:0];

`ifdef ALU_CTRL_VF_RESET_EN
    assign w_vf_clear = (w_n == c_ALU_OR) || (w_n == c_ALU_AND) || (w_n == c_ALU_XOR);
`else
    assign w_vf_clear = 1'b0;
`endif

    assign w_need_f = needs_wb_f(w_n) || w_vf_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_instr    <= 12'h000;
            r_op1      <= 8'h00;
            r_op2      <= 8'h00;
            r_flag     <= 1'b0;
            r_ill_pend <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ill_pend <= 1'b0;
            if (r_state == ST_IDLE && start) begin
                r_instr    <= instr[11:0];
                r_ill_pend <= !is_legal_alu_instr(instr);
            end
            if (r_state == ST_EXEC) begin
                r_op1 <= rf_rdata_x;
                r_op2 <= rf_rdata_y;
            end
            // Flag is frozen here because the ALU output moves on after WB_X.
            if (r_state == ST_WB_X) begin
                r_flag <= w_vf_clear ? 1'b0 : alu_carry;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = r_ill_pend;
        err      = r_ill_pend;
        rf_we    = 1'b0;
        rf_waddr = 4'h0;
        rf_wdata = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (start && is_legal_alu_instr(instr)) begin
                    w_next = ST_READ;
                end
            end
            ST_READ: begin
                busy   = 1'b1;
                w_next = ST_EXEC;
            end
            ST_EXEC: begin
                busy   = 1'b1;
                w_next = ST_WB_X;
            end
            ST_WB_X: begin
                busy = 1'b1;
                if (alu_err) begin
                    done   = 1'b1;
                    err    = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    rf_we    = 1'b1;
                    rf_waddr = w_x;
                    rf_wdata = alu_out;
                    if (needs_wb_y(w_n)) begin
                        w_next = ST_WB_Y;
                    end else if (w_need_f) begin
                        w_next = ST_WB_F;
                    end else begin
                        done   = 1'b1;
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_WB_Y: begin
                busy     = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = w_y;
                rf_wdata = alu_out;
                w_next   = ST_WB_F;
            end
            ST_WB_F: begin
                busy     = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = c_VF_IDX;
                rf_wdata = {7'b0, r_flag};
                done     = 1'b1;
                w_next   = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign rf_raddr_x = w_x;
    assign rf_raddr_y = w_y;
    assign alu_op1    = (r_state == ST_EXEC) ? rf_rdata_x : r_op1;
    assign alu_op2    = (r_state == ST_EXEC) ? rf_rdata_y : r_op2;
    assign alu_opcode = w_n;

endmodule

`default_nettype wire
